segasys1_hvtiming: RTL



---
 rtl/segasys1_vid_pkg.sv | 43 ++++
 rtl/vid_pipe_dly.sv | 33 +++
 rtl/segasys1_hvtiming.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/segasys1_vid_pkg.sv
// Shared definitions for the System 1 video slice: default scan timing, RGB8 field
// layout, the control-bundle type and the palette colour-expansion helpers.
package segasys1_vid_pkg;

    localparam int DEF_H_TOTAL  = 320;
    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_HS_START = 280;
    localparam int DEF_HS_WIDTH = 24;
    localparam int DEF_V_TOTAL  = 260;
    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_VS_START = 236;
    localparam int DEF_VS_WIDTH = 3;
    localparam int DEF_PIX_DLY  = 2;

    localparam int CNT_W   = 9;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // RGB8 palette byte: [2:0] red, [5:3] green, [7:6] blue
    localparam int RGB_R_LSB = 0;
    localparam int RGB_R_MSB = 2;
    localparam int RGB_G_LSB = 3;
    localparam int RGB_G_MSB = 5;
    localparam int RGB_B_LSB = 6;
    localparam int RGB_B_MSB = 7;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } vid_ctrl_t;

    localparam vid_ctrl_t CTRL_RST = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    function automatic logic [3:0] expand3(input logic [2:0] v);
        return {v, v[2]};
    endfunction

    function automatic logic [3:0] expand2(input logic [1:0] v);
        return {v, v};
    endfunction

endpackage

// File: rtl/vid_pipe_dly.sv
// Parameterised shift register for video control bits, with a per-bit reset value.
// DEPTH=0 degenerates into a plain wire.
module vid_pipe_dly #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // NOTE: every stage is reset, not just the last, so no stale blank/sync value can emerge after RESET.
        // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
        always_ff @(posedge vclk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/segasys1_hvtiming.sv
// System 1 scan timing: PH/PV generation, delay-aligned blank/sync and RGB8 expansion.
// Optional sync position adjust via HOFS/VOFS when SEGASYS1_HVTIMING_POSADJ_EN is defined.
module segasys1_hvtiming
    import segasys1_vid_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_WIDTH = DEF_HS_WIDTH,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_WIDTH = DEF_VS_WIDTH,
    parameter int PIX_DLY  = DEF_PIX_DLY
) (
    input  logic              VCLK,
    input  logic              RESET,
`ifdef SEGASYS1_HVTIMING_POSADJ_EN
    input  logic signed [3:0] HOFS,
    input  logic signed [3:0] VOFS,
`endif
    output logic [8:0]        PH,
    output logic [8:0]        PV,
    input  logic [7:0]        RGB8,
    output logic              HBLANK,
    output logic              VBLANK,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              CE_PIX,
    output logic [3:0]        R,
    output logic [3:0]        G,
    output logic [3:0]        B,
    output logic              FRAME_ST
);

    if (H_TOTAL < 1 || H_TOTAL > CNT_MAX || V_TOTAL < 1 || V_TOTAL > CNT_MAX ||
        H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_bad_size
        $error("segasys1_hvtiming: timing parameters exceed 9-bit counter range");
    end

    if (HS_WIDTH < 1 || VS_WIDTH < 1 ||
        HS_START + HS_WIDTH > H_TOTAL || VS_START + VS_WIDTH > V_TOTAL) begin : g_bad_sync
        $error("segasys1_hvtiming: sync window crosses the counter wrap");
    end

    if (PIX_DLY < 0) begin : g_bad_dly
        $error("segasys1_hvtiming: PIX_DLY must be non-negative");
    end

`ifdef SEGASYS1_HVTIMING_POSADJ_EN
    // Offsets span -8..+7; the shifted windows must still stay inside one line/frame
    if (HS_START < 8 || HS_START + 7 + HS_WIDTH > H_TOTAL ||
        VS_START < 8 || VS_START + 7 + VS_WIDTH > V_TOTAL) begin : g_bad_adj
        $error("segasys1_hvtiming: adjusted sync window may cross the counter wrap");
    end
`endif

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
    localparam logic [8:0] HS_BASE = 9'(HS_START);
    localparam logic [8:0] VS_BASE = 9'(VS_START);
    localparam logic [9:0] HS_LEN  = 10'(HS_WIDTH);
    localparam logic [9:0] VS_LEN  = 10'(VS_WIDTH);

    logic [8:0] ph_nxt;
    logic [8:0] pv_nxt;

    // NOTE: defaults are assigned first so every path writes every output and no latch is inferred.
    always_comb begin
        ph_nxt = PH + 9'd1;
        pv_nxt = PV;
        if (PH == H_LAST) begin
            ph_nxt = '0;
            pv_nxt = (PV == V_LAST) ? 9'd0 : PV + 9'd1;
        end
    end

    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            PH       <= '0;
            PV       <= '0;
            FRAME_ST <= 1'b0;
        end else begin
            PH       <= ph_nxt;
            PV       <= pv_nxt;
            FRAME_ST <= (ph_nxt == 9'd0) && (pv_nxt == 9'd0);
        end
    end

    logic [8:0] hs_start;
    logic [8:0] vs_start;

`ifdef SEGASYS1_HVTIMING_POSADJ_EN
    logic signed [3:0] hofs_q;
    logic signed [3:0] vofs_q;

    // Captured at the frame-start edge, so a new offset never changes a window mid-frame
    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            hofs_q <= '0;
            vofs_q <= '0;
        end else if (FRAME_ST) begin
            hofs_q <= HOFS;
            vofs_q <= VOFS;
        end
    end

    assign hs_start = HS_BASE + {{5{hofs_q[3]}}, hofs_q};
    assign vs_start = VS_BASE + {{5{vofs_q[3]}}, vofs_q};
`else
    assign hs_start = HS_BASE;
    assign vs_start = VS_BASE;
`endif

    vid_ctrl_t ctrl_raw;
    vid_ctrl_t ctrl_dly;

    always_comb begin
        ctrl_raw        = CTRL_RST;
        ctrl_raw.hblank = (PH >= H_ACT);
        ctrl_raw.vblank = (PV >= V_ACT);
        ctrl_raw.hsync  = (PH >= hs_start) && ({1'b0, PH} < ({1'b0, hs_start} + HS_LEN));
        ctrl_raw.vsync  = (PV >= vs_start) && ({1'b0, PV} < ({1'b0, vs_start} + VS_LEN));
    end

    // One stage more than PIX_DLY to match the RGB8 capture register
    vid_pipe_dly #(
        .WIDTH  ($bits(vid_ctrl_t)),
        .DEPTH  (PIX_DLY + 1),
        .RST_VAL(CTRL_RST)
    ) u_ctrl_dly (
        .vclk (VCLK),
        .reset(RESET),
        .din  (ctrl_raw),
        .dout (ctrl_dly)
    );

    assign HBLANK = ctrl_dly.hblank;
    assign VBLANK = ctrl_dly.vblank;
    assign HSYNC  = ctrl_dly.hsync;
    assign VSYNC  = ctrl_dly.vsync;
    assign CE_PIX = 1'b1;

    logic [7:0] rgb_q;

    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) rgb_q <= '0;
        else       rgb_q <= RGB8;
    end

    always_comb begin
        R = '0;
        G = '0;
        B = '0;
        if (!(ctrl_dly.hblank || ctrl_dly.vblank)) begin
            R = expand3(rgb_q[RGB_R_MSB:RGB_R_LSB]);
            G = expand3(rgb_q[RGB_G_MSB:RGB_G_LSB]);
            B = expand2(rgb_q[RGB_B_MSB:RGB_B_LSB]);
        end
    end

endmodule
